regfile_wr_arbiter: RTL and testbench

- Shares the single write port of the 16x16 register file between several writeback sources (ALU, load unit, debug/host).
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives the register file's `reg_w_en`, `addr_in` and `reg_in` from a registered issue stage.
- Reports read-after-write hazards against the pending write.

---
 rtl/rf_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int NumReqDef    = 3;
    localparam int DataWidthDef = 16;
    localparam int AddrWidthDef = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal pointer; scanning starts one past the last winner.
module rr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NumReq = NumReqDef,
    localparam int PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NumReq-1:0] req_i,
    input  logic              en_i,
    input  logic              xfer_i,
    output logic [NumReq-1:0] grant_o,
    output logic [PtrW-1:0]   gnt_idx_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] scanIdx;
    logic            found;

    always_comb begin
        grant_o   = '0;
        gnt_idx_o = ptr_q;
        found     = 1'b0;
        scanIdx   = '0;
        for (int off = 1; off <= NumReq; off++) begin
            scanIdx = PtrW'((int'(ptr_q) + off) % NumReq);
            if (en_i && !found && req_i[scanIdx]) begin
                found            = 1'b1;
                grant_o[scanIdx] = 1'b1;
                gnt_idx_o        = scanIdx;
            end
        end
    end

    assign ptr_d = xfer_i ? gnt_idx_o : ptr_q;

    // Reset to the last index so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= PtrW'(NumReq - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between several writeback sources.
// Optional macro RF_ARB_R0_DISCARD_EN: accepted writes to r0 are dropped instead of issued.
module regfile_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NumReq    = NumReqDef,
    parameter int DataWidth = DataWidthDef,
    parameter int AddrWidth = AddrWidthDef
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NumReq-1:0]           req_valid,
    input  logic [NumReq*AddrWidth-1:0] req_addr,
    input  logic [NumReq*DataWidth-1:0] req_data,
    output logic [NumReq-1:0]           req_ready,
    input  logic                        wr_stall,
    output logic                        reg_w_en,
    output logic [AddrWidth-1:0]        reg_addr,
    output logic [DataWidth-1:0]        reg_data,
    input  logic [AddrWidth-1:0]        rd_addr1,
    input  logic [AddrWidth-1:0]        rd_addr2,
    output logic                        rd_hazard1,
    output logic                        rd_hazard2
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

`ifdef RF_ARB_R0_DISCARD_EN
    localparam bit DiscardR0 = 1'b1;
`else
    localparam bit DiscardR0 = 1'b0;
`endif

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic [NumReq-1:0]      grant;
    logic [PtrW-1:0]        gntIdx;
    logic                   arbEn;
    logic                   xfer;
    logic                   capture;
    logic [AddrWidth-1:0]   selAddr;
    logic [DataWidth-1:0]   selData;

    // The stage can accept only when empty or draining this cycle.
    assign arbEn = rst_n && !wr_stall && (state_q != HOLD);

    rr_arbiter #(
        .NumReq (NumReq)
    ) uArb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .en_i      (arbEn),
        .xfer_i    (xfer),
        .grant_o   (grant),
        .gnt_idx_o (gntIdx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign selAddr   = req_addr[int'(gntIdx)*AddrWidth +: AddrWidth];
    assign selData   = req_data[int'(gntIdx)*DataWidth +: DataWidth];
    assign capture   = xfer && !(DiscardR0 && (selAddr == '0));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (capture) begin
            addr_d = selAddr;
            data_d = selData;
        end
        case (state_q)
            IDLE:    if (capture) state_d = ISSUE;
            ISSUE: begin
                if (wr_stall)     state_d = HOLD;
                else if (capture) state_d = ISSUE;
                else              state_d = IDLE;
            end
            HOLD:    if (!wr_stall) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Gating with rst_n keeps a write pending at reset from ever committing.
    assign reg_w_en   = rst_n && (state_q == ISSUE);
    assign reg_addr   = addr_q;
    assign reg_data   = data_q;
    assign rd_hazard1 = (state_q != IDLE) && (addr_q == rd_addr1);
    assign rd_hazard2 = (state_q != IDLE) && (addr_q == rd_addr2);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter (honours RF_ARB_R0_DISCARD_EN if defined).
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        wr_stall;
    logic        reg_w_en;
    logic [3:0]  reg_addr;
    logic [15:0] reg_data;
    logic [3:0]  rd_addr1, rd_addr2;
    logic        rd_hazard1, rd_hazard2;

    int testsRun  = 0;
    int failCount = 0;
    int nineWrites = 0;
    logic [15:0] rfModel [16];

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_stall   (wr_stall),
        .reg_w_en   (reg_w_en),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_hazard1 (rd_hazard1),
        .rd_hazard2 (rd_hazard2)
    );

    // Behaves like the register file on the other side of the write port.
    always @(posedge clk) begin
        if (reg_w_en === 1'b1) begin
            rfModel[reg_addr] <= reg_data;
            if (reg_addr == 4'd9) nineWrites++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0; req_valid = '0; wr_stall = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_stall = 1'b0; req_valid = 3'b111;
        req_addr = '0; req_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        step(); step();
        sample();
        testsRun++; if (req_ready !== 3'b000) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 000", req_ready); end
        testsRun++; if (reg_w_en !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wen: got %b expected 0", reg_w_en); end
        testsRun++; if (reg_addr !== 4'd0 || reg_data !== 16'd0) begin failCount++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 0/0000", reg_addr, reg_data); end
        testsRun++; if (rd_hazard1 !== 1'b0 || rd_hazard2 !== 1'b0) begin failCount++; $display("[TB] FAIL reset_hazard: got %b%b expected 00", rd_hazard1, rd_hazard2); end
        step();
        rst_n = 1'b1; req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 3'b001; req_addr[3:0] = 4'd5; req_data[15:0] = 16'hBEEF;
        sample();
        testsRun++; if (req_ready !== 3'b001) begin failCount++; $display("[TB] FAIL single_ready: got %b expected 001", req_ready); end
        step();
        req_valid = '0;
        sample();
        testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'd5 || reg_data !== 16'hBEEF) begin
            failCount++; $display("[TB] FAIL single_issue: got en=%b addr=%h data=%h expected 1/5/beef", reg_w_en, reg_addr, reg_data); end
        step();
        sample();
        testsRun++; if (reg_w_en !== 1'b0) begin failCount++; $display("[TB] FAIL single_drain: got %b expected 0", reg_w_en); end
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0] expReady;
        doReset();
        req_valid = 3'b111;
        req_addr  = {4'd3, 4'd2, 4'd1};
        req_data  = {16'h0102, 16'h0101, 16'h0100};
        for (int k = 0; k < 6; k++) begin
            if (k == 5) req_valid = '0;
            sample();
            expReady = (k < 5) ? (3'b001 << (k % 3)) : 3'b000;
            testsRun++; if (req_ready !== expReady) begin failCount++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, expReady); end
            if (k > 0) begin
                testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'(((k - 1) % 3) + 1) || reg_data !== 16'(16'h0100 + ((k - 1) % 3))) begin
                    failCount++; $display("[TB] FAIL rr_issue[%0d]: got en=%b addr=%h data=%h expected 1/%0d", k, reg_w_en, reg_addr, reg_data, ((k - 1) % 3) + 1); end
            end
            step();
        end
        sample();
        testsRun++; if (reg_w_en !== 1'b0) begin failCount++; $display("[TB] FAIL rr_drain: got %b expected 0", reg_w_en); end
        step();
    endtask

    task automatic test_stall();
        doReset();
        req_valid = 3'b001; req_addr[3:0] = 4'd7; req_data[15:0] = 16'h0777;
        rd_addr1 = 4'd7; rd_addr2 = 4'd3;
        sample();
        testsRun++; if (req_ready !== 3'b001) begin failCount++; $display("[TB] FAIL stall_grant: got %b expected 001", req_ready); end
        step();
        req_valid = 3'b010; req_addr[7:4] = 4'd8; wr_stall = 1'b1;
        sample();
        testsRun++; if (reg_w_en !== 1'b1 || req_ready !== 3'b000) begin failCount++; $display("[TB] FAIL stall_first: got en=%b ready=%b expected 1/000", reg_w_en, req_ready); end
        for (int c = 0; c < 2; c++) begin
            step();
            sample();
            testsRun++; if (reg_w_en !== 1'b0 || reg_addr !== 4'd7 || req_ready !== 3'b000) begin
                failCount++; $display("[TB] FAIL stall_hold[%0d]: got en=%b addr=%h ready=%b expected 0/7/000", c, reg_w_en, reg_addr, req_ready); end
            testsRun++; if (rd_hazard1 !== 1'b1 || rd_hazard2 !== 1'b0) begin failCount++; $display("[TB] FAIL stall_hazard[%0d]: got %b%b expected 10", c, rd_hazard1, rd_hazard2); end
        end
        step();
        wr_stall = 1'b0;
        sample();
        testsRun++; if (reg_w_en !== 1'b0 || req_ready !== 3'b000) begin failCount++; $display("[TB] FAIL stall_release: got en=%b ready=%b expected 0/000", reg_w_en, req_ready); end
        step();
        req_valid = '0;
        sample();
        testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'd7 || reg_data !== 16'h0777) begin
            failCount++; $display("[TB] FAIL stall_reissue: got en=%b addr=%h data=%h expected 1/7/0777", reg_w_en, reg_addr, reg_data); end
        step();
        sample();
        testsRun++; if (reg_w_en !== 1'b0 || rd_hazard1 !== 1'b0) begin failCount++; $display("[TB] FAIL stall_done: got en=%b haz=%b expected 0/0", reg_w_en, rd_hazard1); end
        step();
    endtask

    task automatic test_same_dest();
        doReset();
        req_valid = 3'b001; req_addr[3:0] = 4'hA; req_data[15:0] = 16'h00AA;
        step();
        req_valid = '0;
        step(); step();
        req_valid = 3'b101;
        req_addr[3:0] = 4'd4;  req_data[15:0]  = 16'd1;
        req_addr[11:8] = 4'd4; req_data[47:32] = 16'd2;
        sample();
        testsRun++; if (req_ready !== 3'b100) begin failCount++; $display("[TB] FAIL same_first: got %b expected 100", req_ready); end
        step();
        req_valid = 3'b001;
        sample();
        testsRun++; if (req_ready !== 3'b001 || reg_w_en !== 1'b1 || reg_data !== 16'd2) begin
            failCount++; $display("[TB] FAIL same_second: got ready=%b en=%b data=%h expected 001/1/0002", req_ready, reg_w_en, reg_data); end
        step();
        req_valid = '0;
        sample();
        testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'd4 || reg_data !== 16'd1) begin
            failCount++; $display("[TB] FAIL same_third: got en=%b addr=%h data=%h expected 1/4/0001", reg_w_en, reg_addr, reg_data); end
        step(); step();
        testsRun++; if (rfModel[4] !== 16'd1) begin failCount++; $display("[TB] FAIL same_final: got %h expected 0001", rfModel[4]); end
    endtask

    task automatic test_reset_pending();
        req_valid = 3'b001; req_addr[3:0] = 4'd9; req_data[15:0] = 16'h9999;
        sample();
        testsRun++; if (req_ready !== 3'b001) begin failCount++; $display("[TB] FAIL rstp_grant: got %b expected 001", req_ready); end
        step();
        rst_n = 1'b0; req_valid = '0;
        sample();
        testsRun++; if (reg_w_en !== 1'b0) begin failCount++; $display("[TB] FAIL rstp_wen: got %b expected 0", reg_w_en); end
        step();
        rst_n = 1'b1;
        req_valid = 3'b011; req_addr[3:0] = 4'd1; req_addr[7:4] = 4'd2;
        sample();
        testsRun++; if (reg_w_en !== 1'b0 || reg_addr !== 4'd0 || req_ready !== 3'b001) begin
            failCount++; $display("[TB] FAIL rstp_restart: got en=%b addr=%h ready=%b expected 0/0/001", reg_w_en, reg_addr, req_ready); end
        step();
        req_valid = '0;
        sample();
        testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'd1) begin failCount++; $display("[TB] FAIL rstp_issue: got en=%b addr=%h expected 1/1", reg_w_en, reg_addr); end
        step(); step();
        testsRun++; if (nineWrites !== 0) begin failCount++; $display("[TB] FAIL rstp_no_nine: got %0d writes expected 0", nineWrites); end
    endtask

    task automatic test_r0();
        req_valid = 3'b010; req_addr[7:4] = 4'd0; req_data[31:16] = 16'h1234;
        rd_addr1 = 4'd0;
        sample();
        testsRun++; if (req_ready !== 3'b010) begin failCount++; $display("[TB] FAIL r0_ready: got %b expected 010", req_ready); end
        step();
        req_valid = '0;
        sample();
`ifdef RF_ARB_R0_DISCARD_EN
        testsRun++; if (reg_w_en !== 1'b0 || rd_hazard1 !== 1'b0) begin failCount++; $display("[TB] FAIL r0_discard: got en=%b haz=%b expected 0/0", reg_w_en, rd_hazard1); end
`else
        testsRun++; if (reg_w_en !== 1'b1 || reg_addr !== 4'd0 || reg_data !== 16'h1234 || rd_hazard1 !== 1'b1) begin
            failCount++; $display("[TB] FAIL r0_issue: got en=%b addr=%h data=%h haz=%b expected 1/0/1234/1", reg_w_en, reg_addr, reg_data, rd_hazard1); end
`endif
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        foreach (rfModel[i]) rfModel[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_same_dest();
        test_reset_pending();
        test_r0();
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
